// File: rtl/noise_pkg.sv
// -----------------------------------------------------------------------------
// noise_pkg
// Shared definitions for the noise statistics block: default sample width,
// the signed sample type, the acquisition state encoding and the histogram
// bin count (used only when NOISE_STAT_HIST_EN is defined).
// -----------------------------------------------------------------------------
package noise_pkg;

    localparam int SAMPLE_W = 24;
    localparam int HBINS    = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DONE = 2'd2
    } stat_state_t;

endpackage : noise_pkg

// File: rtl/noise_hist.sv
// -----------------------------------------------------------------------------
// noise_hist
// 16-bin histogram of the top four sample bits. The sign bit is inverted so
// that bin 0 holds the most negative samples. Bins are 16-bit saturating
// counters. The read port is registered: o_cnt shows bin i_sel one cycle later.
//
// Ports:
//   CK       clock
//   RB       synchronous active-high reset, clears every bin and the read reg
//   i_clr    clear all bins (start of a new acquisition)
//   i_upd    count i_msb into its bin this cycle
//   i_msb    top four bits of the sample, {C[SW-1], C[SW-2:SW-4]}
//   i_sel    bin to read
//   o_cnt    registered count of bin i_sel
// -----------------------------------------------------------------------------
module noise_hist
    import noise_pkg::*;
(
    input  logic        CK,
    input  logic        RB,
    input  logic        i_clr,
    input  logic        i_upd,
    input  logic [3:0]  i_msb,
    input  logic [3:0]  i_sel,
    output logic [15:0] o_cnt
);

    logic [15:0] r_bins [HBINS];
    logic [15:0] r_cnt;
    logic [3:0]  w_idx;

    // Offset-binary index: inverting the sign bit orders bins from most
    // negative (0) to most positive (15).
    assign w_idx = {~i_msb[3], i_msb[2:0]};

    always_ff @(posedge CK) begin
        // NOTE: the bins are a small flop array, not RAM, so clearing every
        // entry in one cycle is legitimate and needed for the start pulse.
        if (RB || i_clr) begin
            for (int i = 0; i < HBINS; i++) begin
                r_bins[i] <= '0;
            end
        end else if (i_upd && (r_bins[w_idx] != 16'hFFFF)) begin
            r_bins[w_idx] <= r_bins[w_idx] + 16'd1;
        end

        if (RB) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_bins[i_sel];
        end
    end

    assign o_cnt = r_cnt;

endmodule : noise_hist

// File: rtl/noise_stat.sv
// -----------------------------------------------------------------------------
// noise_stat
// Accumulates NSAMP valid noise samples after a start pulse and reports count,
// signed sum, unsigned sum of squares and signed min/max. Optional 16-bin
// histogram compiled in with the macro NOISE_STAT_HIST_EN.
//
// Ports:
//   CK        clock
//   RB        synchronous active-high reset (overrides ST and C_vld)
//   ST        one-cycle start pulse: clears statistics, enters ACQ next cycle
//   C         signed sample, C_vld qualifies it (no backpressure)
//   busy      high in ACQ
//   done      high in DONE, results stable
//   cnt       valid samples accumulated
//   sum       signed running sum
//   sumsq     unsigned running sum of squares
//   smin/smax signed minimum / maximum sample
//   hist_sel  histogram bin select      (NOISE_STAT_HIST_EN only)
//   hist_cnt  registered bin count      (NOISE_STAT_HIST_EN only)
// -----------------------------------------------------------------------------
module noise_stat
    import noise_pkg::*;
#(
    parameter int NSAMP = 10000,
    parameter int SW    = SAMPLE_W
) (
    input  logic                  CK,
    input  logic                  RB,
    input  logic                  ST,
    input  logic signed [SW-1:0]  C,
    input  logic                  C_vld,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           cnt,
    output logic signed [SW+15:0] sum,
    output logic [2*SW+15:0]      sumsq,
    output logic signed [SW-1:0]  smin,
    output logic signed [SW-1:0]  smax
`ifdef NOISE_STAT_HIST_EN
    ,
    input  logic [3:0]            hist_sel,
    output logic [15:0]           hist_cnt
`endif
);

    stat_state_t           r_state;
    logic [15:0]           r_cnt;
    logic signed [SW+15:0] r_sum;
    logic [2*SW+15:0]      r_sumsq;
    logic signed [SW-1:0]  r_smin;
    logic signed [SW-1:0]  r_smax;

    logic                  w_take;
    logic                  w_last;
    logic signed [2*SW-1:0] w_c_wide;
    logic signed [2*SW-1:0] w_sq;

    // A sample coinciding with ST belongs to the old acquisition and is dropped.
    assign w_take = (r_state == ACQ) && C_vld && !ST;
    assign w_last = w_take && (r_cnt == 16'(NSAMP - 1));

    // Signed square in 2*SW bits; even (-2^(SW-1))^2 fits, so the result is
    // always non-negative and can be added as unsigned.
    assign w_c_wide = {{SW{C[SW-1]}}, C};
    assign w_sq     = w_c_wide * w_c_wide;

    always_ff @(posedge CK) begin
        if (RB) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_sumsq <= '0;
            r_smin  <= '0;
            r_smax  <= '0;
        end else if (ST) begin
            // smin/smax are not cleared here: the first counted sample
            // overwrites them (r_cnt is zero then).
            r_state <= ACQ;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_sumsq <= '0;
        end else if (w_take) begin
            // NOTE: non-blocking updates so every accumulator sees the
            // pre-edge r_cnt and sample values consistently.
            r_cnt   <= r_cnt + 16'd1;
            r_sum   <= r_sum + {{16{C[SW-1]}}, C};
            r_sumsq <= r_sumsq + {16'd0, $unsigned(w_sq)};
            if (r_cnt == 16'd0) begin
                r_smin <= C;
                r_smax <= C;
            end else begin
                if (C < r_smin) r_smin <= C;
                if (C > r_smax) r_smax <= C;
            end
            if (w_last) begin
                r_state <= DONE;
            end
        end
    end

    assign busy  = (r_state == ACQ);
    assign done  = (r_state == DONE);
    assign cnt   = r_cnt;
    assign sum   = r_sum;
    assign sumsq = r_sumsq;
    assign smin  = r_smin;
    assign smax  = r_smax;

`ifdef NOISE_STAT_HIST_EN
    noise_hist u_hist (
        .CK    (CK),
        .RB    (RB),
        .i_clr (ST),
        .i_upd (w_take),
        .i_msb (C[SW-1:SW-4]),
        .i_sel (hist_sel),
        .o_cnt (hist_cnt)
    );
`endif

endmodule : noise_stat

// File: tb/tb_noise_stat.sv
module tb_noise_stat;
    import noise_pkg::*;

    logic    CK = 1'b0;
    logic    RB, ST, C_vld;
    sample_t C;

    always #5 CK = ~CK;

    logic              busy4, done4, busy10, done10;
    logic [15:0]       cnt4, cnt10;
    logic signed [39:0] sum4, sum10;
    logic [63:0]       sumsq4, sumsq10;
    sample_t           smin4, smax4, smin10, smax10;

`ifdef NOISE_STAT_HIST_EN
    logic [3:0]         hist_sel;
    logic [15:0]        hcnt4, hcnt10, hcnth;
    logic               busyh, doneh;
    logic [15:0]        cnth;
    logic signed [39:0] sumh;
    logic [63:0]        sumsqh;
    sample_t            sminh, smaxh;
`endif

    noise_stat #(.NSAMP(4)) dut4 (
        .CK(CK), .RB(RB), .ST(ST), .C(C), .C_vld(C_vld),
        .busy(busy4), .done(done4), .cnt(cnt4), .sum(sum4), .sumsq(sumsq4),
        .smin(smin4), .smax(smax4)
`ifdef NOISE_STAT_HIST_EN
        , .hist_sel(hist_sel), .hist_cnt(hcnt4)
`endif
    );

    noise_stat #(.NSAMP(10)) dut10 (
        .CK(CK), .RB(RB), .ST(ST), .C(C), .C_vld(C_vld),
        .busy(busy10), .done(done10), .cnt(cnt10), .sum(sum10), .sumsq(sumsq10),
        .smin(smin10), .smax(smax10)
`ifdef NOISE_STAT_HIST_EN
        , .hist_sel(hist_sel), .hist_cnt(hcnt10)
`endif
    );

`ifdef NOISE_STAT_HIST_EN
    noise_stat #(.NSAMP(65535)) duth (
        .CK(CK), .RB(RB), .ST(ST), .C(C), .C_vld(C_vld),
        .busy(busyh), .done(doneh), .cnt(cnth), .sum(sumh), .sumsq(sumsqh),
        .smin(sminh), .smax(smaxh), .hist_sel(hist_sel), .hist_cnt(hcnth)
    );
`endif

    typedef struct {
        string              name;
        sample_t            samp [4];
        bit                 gaps;
        bit                 st_vld;
        sample_t            st_c;
        logic [15:0]        e_cnt;
        logic signed [39:0] e_sum;
        logic [63:0]        e_sumsq;
        sample_t            e_smin;
        sample_t            e_smax;
    } vec_t;

    typedef struct {
        logic [15:0]        cnt;
        logic signed [39:0] sum;
        logic [63:0]        sumsq;
        sample_t            smin;
        sample_t            smax;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic set_vec(input int idx, input string name,
                           input sample_t s0, input sample_t s1, input sample_t s2, input sample_t s3,
                           input bit gaps, input bit st_vld, input sample_t st_c,
                           input logic signed [39:0] e_sum, input logic [63:0] e_sumsq,
                           input sample_t e_smin, input sample_t e_smax);
        vecs[idx].name    = name;
        vecs[idx].samp[0] = s0;
        vecs[idx].samp[1] = s1;
        vecs[idx].samp[2] = s2;
        vecs[idx].samp[3] = s3;
        vecs[idx].gaps    = gaps;
        vecs[idx].st_vld  = st_vld;
        vecs[idx].st_c    = st_c;
        vecs[idx].e_cnt   = 16'd4;
        vecs[idx].e_sum   = e_sum;
        vecs[idx].e_sumsq = e_sumsq;
        vecs[idx].e_smin  = e_smin;
        vecs[idx].e_smax  = e_smax;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        ST = 1'b1; C_vld = v.st_vld; C = v.st_c;
        step();
        ST = 1'b0; C_vld = 1'b0;
        check({v.name, "/busy_after_st"}, {63'd0, busy4}, 64'd1);
        check({v.name, "/cnt_cleared"}, {48'd0, cnt4}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                check({v.name, "/no_early_done"}, {63'd0, done4}, 64'd0);
                e.cnt   = v.e_cnt;
                e.sum   = v.e_sum;
                e.sumsq = v.e_sumsq;
                e.smin  = v.e_smin;
                e.smax  = v.e_smax;
                sb.push_back(e);
            end
            C = v.samp[i]; C_vld = 1'b1;
            step();
            C_vld = 1'b0;
            if (v.gaps) begin
                C = 24'sd99;
                step();
            end
        end
        check({v.name, "/done"}, {63'd0, done4}, 64'd1);
        check({v.name, "/busy_low"}, {63'd0, busy4}, 64'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({v.name, "/cnt"},   {48'd0, cnt4}, {48'd0, e.cnt});
            check({v.name, "/sum"},   sum4, e.sum);
            check({v.name, "/sumsq"}, sumsq4, e.sumsq);
            check({v.name, "/smin"},  smin4, e.smin);
            check({v.name, "/smax"},  smax4, e.smax);
        end
    endtask

    initial begin
        RB = 1'b1; ST = 1'b1; C_vld = 1'b1; C = 24'sd5;
`ifdef NOISE_STAT_HIST_EN
        hist_sel = 4'd0;
`endif
        set_vec(0, "basic",      24'sd5, -24'sd3, 24'sd7, 24'sd0, 1'b0, 1'b0, 24'sd0,
                40'sd9, 64'd83, -24'sd3, 24'sd7);
        set_vec(1, "st_cycle",   24'sd1, 24'sd1, 24'sd1, 24'sd1, 1'b0, 1'b1, 24'sd100,
                40'sd4, 64'd4, 24'sd1, 24'sd1);
        set_vec(2, "extremes",   24'sh7FFFFF, -24'sd8388608, 24'sh7FFFFF, -24'sd8388608,
                1'b0, 1'b0, 24'sd0,
                -40'sd2, 64'h0000_FFFF_FE00_0002, -24'sd8388608, 24'sh7FFFFF);
        set_vec(3, "gapped_neg", -24'sd1, -24'sd2, -24'sd3, -24'sd4, 1'b1, 1'b0, 24'sd0,
                -40'sd10, 64'd30, -24'sd4, -24'sd1);
        set_vec(4, "restart",    24'sd1, 24'sd1, 24'sd1, 24'sd1, 1'b0, 1'b0, 24'sd0,
                40'sd4, 64'd4, 24'sd1, 24'sd1);

        // Reset overrides ST and C_vld.
        step(); step();
        RB = 1'b0; ST = 1'b0; C_vld = 1'b0;
        check("rst/busy",  {63'd0, busy4}, 64'd0);
        check("rst/done",  {63'd0, done4}, 64'd0);
        check("rst/cnt",   {48'd0, cnt4}, 64'd0);
        check("rst/sum",   sum4, 64'd0);
        check("rst/sumsq", sumsq4, 64'd0);
        check("rst/smin",  smin4, 64'd0);
        check("rst/smax",  smax4, 64'd0);

        // Samples in IDLE are ignored.
        for (int i = 0; i < 3; i++) begin
            C = 24'sd7; C_vld = 1'b1;
            step();
        end
        C_vld = 1'b0;
        check("idle/cnt",  {48'd0, cnt4}, 64'd0);
        check("idle/sum",  sum4, 64'd0);
        check("idle/busy", {63'd0, busy4}, 64'd0);

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v]);
        end

        // Samples in DONE are ignored, results hold.
        for (int i = 0; i < 3; i++) begin
            C = 24'sd9; C_vld = 1'b1;
            step();
        end
        C_vld = 1'b0;
        check("done_hold/cnt",  {48'd0, cnt4}, 64'd4);
        check("done_hold/sum",  sum4, 64'd4);
        check("done_hold/smax", smax4, 64'd1);
        check("done_hold/done", {63'd0, done4}, 64'd1);

        // ST in ACQ restarts, sample in the ST cycle dropped.
        ST = 1'b1; step(); ST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            C = 24'sd3; C_vld = 1'b1;
            step();
        end
        check("mid_acq/cnt2", {48'd0, cnt4}, 64'd2);
        check("mid_acq/sum6", sum4, 64'd6);
        ST = 1'b1; C = 24'sd3; C_vld = 1'b1;
        step();
        ST = 1'b0; C_vld = 1'b0;
        check("mid_acq/cnt_clr",   {48'd0, cnt4}, 64'd0);
        check("mid_acq/sum_clr",   sum4, 64'd0);
        check("mid_acq/sumsq_clr", sumsq4, 64'd0);
        check("mid_acq/busy",      {63'd0, busy4}, 64'd1);

        // Reset mid-acquisition on the NSAMP=10 instance.
        for (int i = 0; i < 5; i++) begin
            C = 24'sd2; C_vld = 1'b1;
            step();
        end
        C_vld = 1'b0;
        check("rb_mid/cnt5",  {48'd0, cnt10}, 64'd5);
        check("rb_mid/sum10", sum10, 64'd10);
        RB = 1'b1; step(); RB = 1'b0;
        check("rb_mid/busy",  {63'd0, busy10}, 64'd0);
        check("rb_mid/done",  {63'd0, done10}, 64'd0);
        check("rb_mid/cnt",   {48'd0, cnt10}, 64'd0);
        check("rb_mid/sum",   sum10, 64'd0);
        check("rb_mid/sumsq", sumsq10, 64'd0);
        check("rb_mid/smin",  smin10, 64'd0);
        check("rb_mid/smax",  smax10, 64'd0);
        for (int i = 0; i < 10; i++) begin
            C = 24'sd2; C_vld = 1'b1;
            step();
        end
        C_vld = 1'b0;
        check("rb_mid/no_st_cnt",  {48'd0, cnt10}, 64'd0);
        check("rb_mid/no_st_done", {63'd0, done10}, 64'd0);

`ifdef NOISE_STAT_HIST_EN
        ST = 1'b1; step(); ST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            C = -24'sd8388608; C_vld = 1'b1;
            step();
        end
        for (int i = 0; i < 70000; i++) begin
            C = 24'sh100000; C_vld = 1'b1;
            step();
        end
        C_vld = 1'b0;
        check("hist/done", {63'd0, doneh}, 64'd1);
        check("hist/cnt",  {48'd0, cnth}, 64'd65535);
        hist_sel = 4'd0; step();
        check("hist/bin0", {48'd0, hcnth}, 64'd3);
        hist_sel = 4'd9; step();
        check("hist/bin9", {48'd0, hcnth}, 64'd65532);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_noise_stat

// File: doc/noise_stat.md
NOISE_STAT -- requirements
Module: noise_stat

Interface
REQ-001 Parameter NSAMP, default 10000: number of valid samples per acquisition (1..65535).
REQ-002 Parameter SW, default 24: sample width, signed two's complement.
REQ-003 CK  input  1  rising-edge clock; single clock domain.
REQ-004 RB  input  1  reset; synchronous and active-high (RB=1 at a CK rising edge resets the block).
REQ-005 ST  input  1  one-cycle start pulse; clears statistics and begins acquisition.
REQ-006 C  input  SW  noise sample from the transform stage.
REQ-007 C_vld  input  1  C valid this cycle; no backpressure.
REQ-008 busy  output  1  acquisition in progress.
REQ-009 done  output  1  level; NSAMP samples accumulated, results stable.
REQ-010 cnt  output  16  valid samples accumulated so far.
REQ-011 sum  output  SW+16  signed running sum of samples.
REQ-012 sumsq  output  2*SW+16  unsigned running sum of squared samples.
REQ-013 smin / smax  output  SW each  signed minimum / maximum sample seen.

Function
REQ-014 FSM states SHALL be IDLE, ACQ, DONE; the reset state SHALL be IDLE.
REQ-015 IDLE->ACQ on ST; ACQ->DONE on the cycle the NSAMP-th valid sample is accumulated; DONE->ACQ on ST.
REQ-016 ST in any state SHALL clear cnt, sum, sumsq, and histogram, and SHALL enter ACQ next cycle.
REQ-017 A sample with C_vld=1 in the same cycle as ST SHALL NOT be counted; the first counted sample is the cycle after ST.
REQ-018 In ACQ, each C_vld=1 cycle SHALL update cnt, sum, sumsq, smin, and smax, all visible one cycle later.
REQ-019 The first counted sample after ST SHALL load smin and smax directly; later samples compare signed.
REQ-020 sum SHALL sign-extend C; sumsq SHALL add C*C as an unsigned 2*SW product; no accumulator SHALL overflow for NSAMP<=65535.
REQ-021 busy=1 exactly in ACQ; done=1 exactly in DONE.
REQ-022 C_vld in IDLE or DONE SHALL be ignored; outputs SHALL hold.
REQ-023 The block SHALL NOT apply backpressure; every C_vld cycle in ACQ SHALL be consumed.

Reset
REQ-024 RB=1 SHALL force IDLE with busy=0, done=0, cnt=0, sum=0, sumsq=0, smin=0, smax=0, and all histogram bins=0, overriding ST and C_vld.
REQ-025 RB asserted mid-ACQ SHALL discard the partial acquisition; after release, a new ST is required.

Configuration
REQ-026 Macro NOISE_STAT_HIST_EN SHALL compile in a 16-bin histogram.
- Bin index = {~C[SW-1], C[SW-2:SW-4]}, so bin 0 is the most negative.
- Bins are 16-bit counters that saturate at 0xFFFF.
- Ports: hist_sel input 4, hist_cnt output 16; hist_cnt is registered, one-cycle latency from hist_sel.
- Bins update under the same count and clear rules as REQ-016..REQ-018.
REQ-027 Without NOISE_STAT_HIST_EN, the hist_sel/hist_cnt ports and all histogram storage SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package noise_pkg SHALL hold SAMPLE_W=24, typedef sample_t (signed), the state enum stat_state_t, and HBINS=16.
REQ-029 The histogram SHALL be a sub-module noise_hist, instantiated only under NOISE_STAT_HIST_EN.

Verification
REQ-030 NSAMP=4; ST, then samples 5, -3, 7, 0 -> done=1 one cycle after the 4th sample; sum=9; sumsq=83; smin=-3; smax=7; cnt=4.
REQ-031 NSAMP=4; C_vld=1 with C=100 in the ST cycle, then 1, 1, 1, 1 -> sum=4; smax=1; the sample 100 is not counted.
REQ-032 NSAMP=4; samples 0x7FFFFF and 0x800000 alternating -> smax=0x7FFFFF; smin=0x800000 (-8388608); sum=-2; sumsq=4*2^46-2*2^24+2; no wrap.
REQ-033 NSAMP=10; RB pulse after 5 samples -> all outputs 0, state IDLE; a further 10 samples with no ST leave cnt=0.
REQ-034 ST during DONE, then 4 samples of 1 with NSAMP=4 -> prior results cleared; sum=4; done reasserts.
REQ-035 With NOISE_STAT_HIST_EN: 3 samples of -8388608 and 70000 samples of 0x100000, NSAMP=65535 -> hist_cnt[0]=3; hist_cnt[9]=65532; the counter stops at 65535 samples total, so no saturation is reached.
